// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and the iterative-op classifier
// used by the seq_alu top level and its multiply/divide engine.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLTU = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SRA  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_MULU = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;
  localparam logic [3:0] ALU_DIV  = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op >= ALU_MULU) && (op <= ALU_DIV);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Start/busy/done request bus between the control unit and seq_alu.
interface seq_alu_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       ALUOpcode;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] resultHi;
  logic             zero;
  logic             sign;
  logic             overflow;

  modport master (output start, ALUOpcode, regA, regB,
                  input  busy, done, result, resultHi, zero, sign, overflow);
  modport slave  (input  start, ALUOpcode, regA, regB,
                  output busy, done, result, resultHi, zero, sign, overflow);
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider on one shared WIDTH-bit
// adder; operands are made unsigned on entry and sign-corrected on exit.
module alu_muldiv_iter
  import alu_pkg::*;
#(parameter int WIDTH = 32)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]   acc_q, mq_q, opd_q;
  logic [SHW-1:0]     cnt_q;
  logic               run_q, fin_q, mul_q, neg_lo_q, neg_hi_q;
  logic               is_mul, sgn, a_neg, b_neg, fits;
  logic [WIDTH-1:0]   a_abs, b_abs, add_a, add_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign is_mul = (op == ALU_MULU) || (op == ALU_MUL);
  assign sgn    = (op == ALU_MUL)  || (op == ALU_DIV);
  assign a_neg  = sgn & a[WIDTH-1];
  assign b_neg  = sgn & b[WIDTH-1];
  assign a_abs  = a_neg ? -a : a;
  assign b_abs  = b_neg ? -b : b;

  // Multiply adds the multiplicand when the low multiplier bit is set;
  // divide subtracts the divisor from the partial remainder shifted left.
  assign add_a = mul_q ? acc_q : {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
  assign add_b = mul_q ? (mq_q[0] ? opd_q : '0) : ~opd_q;
  assign sum   = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, ~mul_q};
  assign fits  = acc_q[WIDTH-1] | sum[WIDTH];

  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_lo_q ? -prod : prod;

  assign busy = run_q | fin_q;
  assign done = fin_q;
  assign lo   = mul_q ? prod_fix[WIDTH-1:0]       : (neg_lo_q ? -mq_q  : mq_q);
  assign hi   = mul_q ? prod_fix[2*WIDTH-1:WIDTH] : (neg_hi_q ? -acc_q : acc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      fin_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      opd_q    <= '0;
      mul_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      if (start) begin
        run_q    <= 1'b1;
        cnt_q    <= '0;
        acc_q    <= '0;
        mq_q     <= a_abs;
        opd_q    <= b_abs;
        mul_q    <= is_mul;
        // Divide-by-zero keeps the all-ones quotient unnegated.
        neg_lo_q <= is_mul ? (a_neg ^ b_neg) : ((a_neg ^ b_neg) & (b != '0));
        neg_hi_q <= a_neg;
      end else if (run_q) begin
        cnt_q <= cnt_q + SHW'(1);
        if (&cnt_q) begin
          run_q <= 1'b0;
          fin_q <= 1'b1;
        end
        if (mul_q) begin
          acc_q <= sum[WIDTH:1];
          mq_q  <= {sum[0], mq_q[WIDTH-1:1]};
        end else begin
          acc_q <= fits ? sum[WIDTH-1:0] : add_a;
          mq_q  <= {mq_q[WIDTH-2:0], fits};
        end
      end
    end
  end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with start/busy/done handshake; single-cycle ops finish in
// one clock. Define SEQ_ALU_MULDIV_EN to enable the iterative MUL/DIV engine.
module seq_alu
  import alu_pkg::*;
#(parameter int WIDTH = 32)
(
  input  logic   CLK,
  input  logic   Reset,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state_q;
  logic             busy_q, done_q, zero_q, sign_q, ovf_q;
  logic [WIDTH-1:0] res_q, hi_q;
  logic [WIDTH-1:0] a, b, sum_ab, dif_ab, res_d;
  logic             ovf_d, accept, go_iter, md_busy, md_done;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign a      = bus.regA;
  assign b      = bus.regB;
  assign shamt  = a[SHW-1:0];
  assign sum_ab = a + b;
  assign dif_ab = a - b;
  assign accept = bus.start & ~busy_q & ~md_busy;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (bus.ALUOpcode)
      ALU_ADD: begin
        res_d = sum_ab;
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = dif_ab;
        ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ab[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLL:  res_d = b << shamt;
      ALU_SRL:  res_d = b >> shamt;
      ALU_SRA:  res_d = WIDTH'($signed(b) >>> shamt);
      ALU_OR:   res_d = a | b;
      ALU_AND:  res_d = a & b;
      ALU_XOR:  res_d = a ^ b;
      ALU_NOR:  res_d = ~(a | b);
      default:  res_d = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  assign go_iter = is_iterative(bus.ALUOpcode);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (CLK),
    .rst   (Reset),
    .start (accept & go_iter),
    .op    (bus.ALUOpcode),
    .a     (a),
    .b     (b),
    .busy  (md_busy),
    .done  (md_done),
    .lo    (md_lo),
    .hi    (md_hi)
  );
`else
  assign go_iter = 1'b0;
  assign md_busy = 1'b0;
  assign md_done = 1'b0;
  assign md_lo   = '0;
  assign md_hi   = '0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_RUN: if (md_done) begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          res_q   <= md_lo;
          hi_q    <= md_hi;
          zero_q  <= (md_lo == '0);
          sign_q  <= md_lo[WIDTH-1];
          ovf_q   <= 1'b0;
        end
        default: if (accept && go_iter) begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
        end else if (accept) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          res_q   <= res_d;
          hi_q    <= '0;
          zero_q  <= (res_d == '0);
          sign_q  <= res_d[WIDTH-1];
          ovf_q   <= ovf_d;
        end else begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.resultHi = hi_q;
  assign bus.zero     = zero_q;
  assign bus.sign     = sign_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: a 32-bit and an 8-bit instance share the
// clock/reset; expected results are queued at issue and checked on done.
module tb_seq_alu;
  import alu_pkg::*;

`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  seq_alu_if #(.WIDTH(32)) b32 ();
  seq_alu_if #(.WIDTH(8))  b8  ();

  seq_alu #(.WIDTH(32)) dut  (.CLK(CLK), .Reset(Reset), .bus(b32));
  seq_alu #(.WIDTH(8))  dut8 (.CLK(CLK), .Reset(Reset), .bus(b8));

  typedef struct {
    string       nm;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z;
    logic        s;
    logic        o;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        o;
  } vec_t;

  exp_t q32[$];
  exp_t q8[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected record for an op issued now; accepted at the next rising edge.
  function automatic exp_t mk(string nm, int w, logic [3:0] op,
                              logic [31:0] res, logic [31:0] hi, logic o);
    exp_t        e;
    logic [31:0] m;
    bit          it;
    it = MD_EN && (op >= 4'd11) && (op <= 4'd14);
    m  = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    if (!MD_EN && (op >= 4'd11) && (op <= 4'd14)) begin
      res = '0;
      hi  = '0;
      o   = 1'b0;
    end
    e.nm  = nm;
    e.res = res & m;
    e.hi  = hi & m;
    e.z   = (e.res == 32'd0);
    e.s   = e.res[w-1];
    e.o   = o;
    e.cyc = cyc + (it ? w + 2 : 1);
    return e;
  endfunction

  task automatic check_txn(exp_t e, logic [31:0] r, logic [31:0] h,
                           logic z, logic s, logic o, logic bsy);
    chk({e.nm, "_result"},   r,   e.res);
    chk({e.nm, "_resultHi"}, h,   e.hi);
    chk({e.nm, "_zero"},     {31'd0, z}, {31'd0, e.z});
    chk({e.nm, "_sign"},     {31'd0, s}, {31'd0, e.s});
    chk({e.nm, "_overflow"}, {31'd0, o}, {31'd0, e.o});
    chk({e.nm, "_done_cycle"}, cyc, e.cyc);
    chk({e.nm, "_busy_at_done"}, {31'd0, bsy}, 32'd0);
  endtask

  always @(negedge CLK) begin
    if (!Reset && b32.done) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done32_spurious: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        check_txn(q32.pop_front(), b32.result, b32.resultHi,
                  b32.zero, b32.sign, b32.overflow, b32.busy);
      end
    end
  end

  always @(negedge CLK) begin
    if (!Reset && b8.done) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_spurious: got done=1 at cycle %0d expected no pending op", cyc);
      end else begin
        check_txn(q8.pop_front(), {24'd0, b8.result}, {24'd0, b8.resultHi},
                  b8.zero, b8.sign, b8.overflow, b8.busy);
      end
    end
  end

  task automatic tv(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                    logic [31:0] res, logic [31:0] hi, logic o);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.hi = hi; v.o = o;
    tbl.push_back(v);
  endtask

  // Drives start for the next edge and leaves it high; idle() drops it.
  task automatic issue(bit is8, string nm, logic [3:0] op, logic [31:0] a,
                       logic [31:0] b, logic [31:0] res, logic [31:0] hi, logic o);
    @(negedge CLK);
    if (is8) begin
      b8.start = 1'b1; b8.ALUOpcode = op; b8.regA = a[7:0]; b8.regB = b[7:0];
      q8.push_back(mk(nm, 8, op, res, hi, o));
    end else begin
      b32.start = 1'b1; b32.ALUOpcode = op; b32.regA = a; b32.regB = b;
      q32.push_back(mk(nm, 32, op, res, hi, o));
    end
  endtask

  task automatic idle();
    @(negedge CLK);
    b32.start = 1'b0;
    b8.start  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (q32.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d ops pending expected 0/0", q32.size(), q8.size());
      q32.delete();
      q8.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    b32.start = 1'b0; b32.ALUOpcode = '0; b32.regA = '0; b32.regB = '0;
    b8.start  = 1'b0; b8.ALUOpcode  = '0; b8.regA  = '0; b8.regB  = '0;
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_busy",     {31'd0, b32.busy},     32'd0);
    chk("rst_done",     {31'd0, b32.done},     32'd0);
    chk("rst_result",   b32.result,            32'd0);
    chk("rst_resultHi", b32.resultHi,          32'd0);
    chk("rst_zero",     {31'd0, b32.zero},     32'd0);
    chk("rst_sign",     {31'd0, b32.sign},     32'd0);
    chk("rst_overflow", {31'd0, b32.overflow}, 32'd0);
    chk("rst8_done",    {31'd0, b8.done},      32'd0);
    Reset = 1'b0;

    tv(ALU_ADD,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 0, 1'b1);
    tv(ALU_SUB,  32'd5,         32'd5,          32'd0,         0, 1'b0);
    tv(ALU_SUB,  32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 0, 1'b1);
    tv(ALU_ADD,  32'hFFFF_FFFF, 32'd1,          32'd0,         0, 1'b0);
    tv(ALU_ADD,  32'h8000_0000, 32'h8000_0000,  32'd0,         0, 1'b1);
    tv(ALU_SLT,  32'hFFFF_FFFF, 32'd1,          32'd1,         0, 1'b0);
    tv(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,          32'd0,         0, 1'b0);
    tv(ALU_SLTU, 32'd1,         32'hFFFF_FFFF,  32'd1,         0, 1'b0);
    tv(ALU_SLL,  32'h24,        32'd1,          32'h10,        0, 1'b0);
    tv(ALU_SRL,  32'h21,        32'h8000_0000,  32'h4000_0000, 0, 1'b0);
    tv(ALU_SRA,  32'h24,        32'h8000_0000,  32'hF800_0000, 0, 1'b0);
    tv(ALU_SRA,  32'h4,         32'h4000_0000,  32'h0400_0000, 0, 1'b0);
    tv(ALU_OR,   32'hF0,        32'h0F,         32'hFF,        0, 1'b0);
    tv(ALU_AND,  32'hF0F0,      32'hFF00,       32'hF000,      0, 1'b0);
    tv(ALU_XOR,  32'hF0F0,      32'h0FF0,       32'hFF00,      0, 1'b0);
    tv(ALU_NOR,  32'd0,         32'd0,          32'hFFFF_FFFF, 0, 1'b0);
    tv(4'd15,    32'd5,         32'd6,          32'd0,         0, 1'b0);
    tv(ALU_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFE, 1'b0);
    tv(ALU_MUL,  32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
    tv(ALU_MUL,  32'h8000_0000, 32'h8000_0000,  32'd0,         32'h4000_0000, 1'b0);
    tv(ALU_DIVU, 32'd100,       32'd7,          32'd14,        32'd2,         1'b0);
    tv(ALU_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    tv(ALU_DIV,  32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,         1'b0);
    tv(ALU_DIVU, 32'd9,         32'd0,          32'hFFFF_FFFF, 32'd9,         1'b0);
    tv(ALU_DIV,  32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
    tv(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,         1'b0);

    foreach (tbl[i]) begin
      issue(0, $sformatf("vec%0d_op%0d", i, tbl[i].op), tbl[i].op, tbl[i].a,
            tbl[i].b, tbl[i].res, tbl[i].hi, tbl[i].o);
      idle();
      drain();
    end

    // Reset mid-operation: outputs clear, nothing completes afterwards.
    issue(0, "pre_rst_add", ALU_ADD, 32'd40, 32'd2, 32'd42, 0, 1'b0);
    idle();
    drain();
    if (MD_EN) begin
      @(negedge CLK);
      b32.start = 1'b1; b32.ALUOpcode = ALU_DIVU; b32.regA = 32'd100; b32.regB = 32'd7;
      @(negedge CLK);
      b32.start = 1'b0;
      repeat (5) @(negedge CLK);
      chk("busy_mid_run", {31'd0, b32.busy}, 32'd1);
    end
    Reset = 1'b1;
    @(negedge CLK);
    chk("rstrun_busy",   {31'd0, b32.busy}, 32'd0);
    chk("rstrun_done",   {31'd0, b32.done}, 32'd0);
    chk("rstrun_result", b32.result,        32'd0);
    chk("rstrun_state",  {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    Reset = 1'b0;
    issue(0, "post_rst_add", ALU_ADD, 32'd2, 32'd3, 32'd5, 0, 1'b0);
    idle();
    drain();
    repeat (40) @(negedge CLK);

    // start pulses while busy must be ignored.
    if (MD_EN) begin
      issue(0, "mul_busy", ALU_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0);
      idle();
      repeat (3) @(negedge CLK);
      b32.start = 1'b1; b32.ALUOpcode = ALU_ADD; b32.regA = 32'd1; b32.regB = 32'd1;
      repeat (6) @(negedge CLK);
      chk("busy_hold", {31'd0, b32.busy}, 32'd1);
      b32.start = 1'b0;
      drain();
      repeat (5) @(negedge CLK);
    end

    // Back-to-back accepts from the DONE state.
    issue(0, "b2b_add", ALU_ADD, 32'h10, 32'h22, 32'h32, 0, 1'b0);
    issue(0, "b2b_xor", ALU_XOR, 32'hF0F0, 32'h0FF0, 32'hFF00, 0, 1'b0);
    idle();
    drain();
    issue(0, "b2b_add2", ALU_ADD, 32'd1, 32'd1, 32'd2, 0, 1'b0);
    issue(0, "b2b_mulu", ALU_MULU, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0);
    idle();
    drain();

    // 8-bit instance.
    issue(1, "w8_mul", ALU_MUL, 32'hFD, 32'd7, 32'hEB, 32'hFF, 1'b0);
    idle();
    drain();
    issue(1, "w8_add_ovf", ALU_ADD, 32'h7F, 32'h01, 32'h80, 0, 1'b1);
    issue(1, "w8_sra", ALU_SRA, 32'h0A, 32'h80, 32'hE0, 0, 1'b0);
    idle();
    drain();
    issue(1, "w8_divu", ALU_DIVU, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0);
    idle();
    drain();

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
